// File: rtl/level_step_ctrl_pkg.sv
// Shared types and constants for the level stepper.
// Level range limits and the per-button FSM state encoding.
package level_step_ctrl_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 3'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

endpackage

// File: rtl/level_step_ctrl_btn_conditioner.sv
// One push-button: 2-flop sync, debounce, and press/hold/repeat FSM.
// Emits a registered one-cycle req per accepted step.
module btn_conditioner
  import level_step_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd5000000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  logic        s1;
  logic        s2;
  logic        db;
  logic [15:0] db_cnt;

  btn_state_e  state;
  btn_state_e  state_d;
  logic [23:0] timer;
  logic [23:0] timer_d;
  logic        req_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db     <= 1'b0;
      db_cnt <= 16'd0;
    end else if (s2 == db) begin
      db_cnt <= 16'd0;
    end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
      db     <= ~db;
      db_cnt <= 16'd0;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end

  // The timer also holds at zero in the req cycle, so each
  // hold/repeat period spans one cycle more than its count.
  always_comb begin
    state_d = state;
    timer_d = timer + 24'd1;
    req_d   = 1'b0;
    unique case (state)
      IDLE: begin
        timer_d = 24'd0;
        if (db) begin
          state_d = HOLD;
          req_d   = 1'b1;
        end
      end
      HOLD: begin
        if (!db) begin
          state_d = IDLE;
          timer_d = 24'd0;
        end else if (req) begin
          timer_d = 24'd0;
        end else if (timer == HOLD_CYCLES - 24'd1) begin
          state_d = REPEAT;
          req_d   = 1'b1;
          timer_d = 24'd0;
        end
      end
      REPEAT: begin
        if (!db) begin
          state_d = IDLE;
          timer_d = 24'd0;
        end else if (req) begin
          timer_d = 24'd0;
        end else if (timer == REPEAT_CYCLES - 24'd1) begin
          req_d   = 1'b1;
          timer_d = 24'd0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 24'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= 24'd0;
      req   <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      req   <= req_d;
    end
  end

endmodule

// File: rtl/level_step_ctrl.sv
// Up/down buttons to a 0..7 level code for the bar decoder.
// Holds the level register, step pulse and range flags.
module level_step_ctrl
  import level_step_ctrl_pkg::*;
#(
  parameter logic [15:0]        DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0]        HOLD_CYCLES     = 24'd5000000,
  parameter logic [23:0]        REPEAT_CYCLES   = 24'd2500000,
  parameter logic               WRAP            = 1'b0,
  parameter logic [LEVEL_W-1:0] RESET_LEVEL     = 3'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [LEVEL_W-1:0] level,
  output logic               step,
  output logic               at_max,
  output logic               at_min
);

  logic               up_req;
  logic               dn_req;
  logic [LEVEL_W-1:0] level_d;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .req  (up_req)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_dn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .req  (dn_req)
  );

  always_comb begin
    level_d = level;
    unique case (1'b1)
      up_req && !dn_req: begin
        if (level != LEVEL_MAX)
          level_d = level + 3'd1;
        else if (WRAP)
          level_d = LEVEL_MIN;
      end
      dn_req && !up_req: begin
        if (level != LEVEL_MIN)
          level_d = level - 3'd1;
        else if (WRAP)
          level_d = LEVEL_MAX;
      end
      default: level_d = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= RESET_LEVEL;
      step  <= 1'b0;
    end else begin
      level <= level_d;
      step  <= (level_d != level);
    end
  end

  assign at_max = (level == LEVEL_MAX);
  assign at_min = (level == LEVEL_MIN);

endmodule
